// File: rtl/eth_latency_measurer_rx.sv
// Receive-side parser for latency-measurement ICMP echo frames.
// Byte-wide AXI-Stream input. The block checks the Ethernet/IPv4/ICMP headers
// against the configured addresses and the expected ICMP type. For each
// accepted frame it reports the IP identification, ICMP identifier and ICMP
// sequence fields.
module eth_latency_measurer_rx #(
    parameter int C_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rx_begin,
    input  logic [47:0] mac_addr_local,
    input  logic [47:0] mac_addr_remote,
    input  logic [31:0] ip_addr_local,
    input  logic [31:0] ip_addr_remote,
    output logic        rx_valid,
    output logic [15:0] rx_frame_id,
    output logic [15:0] rx_log_id,
    output logic [15:0] rx_ping_id,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid
);

    typedef enum logic {ST_HEADER, ST_PAYLOAD} state_t;

    localparam logic [15:0] HDR_LAST  = 16'd41;
    localparam logic [15:0] CHK_BYTES = 16'd36;
    localparam logic [7:0]  ICMP_TYPE = (C_MODE != 0) ? 8'h08 : 8'h00;

    // One bit per header byte 0..35, MSB = byte 0. A set bit means the byte is compared.
    localparam logic [35:0] CHK_MASK = 36'b111111111111_111_0_11_00000_1_00_1111111111;

    state_t      state;
    logic [15:0] count;
    logic        match;
    logic [15:0] frame_cap, log_cap, ping_cap;
    logic [15:0] frame_nxt, log_nxt, ping_nxt;
    logic        byte_ok, match_nxt, accept;
    logic [287:0] tmpl, tmpl_sh;
    logic [35:0]  mask_sh;

    // Expected header bytes 0..35. Wildcard positions are zero and are masked out.
    assign tmpl = {mac_addr_local, mac_addr_remote, 16'h0800, 8'h45, 8'h00, 16'h001C,
                   40'h0, 8'h01, 16'h0, ip_addr_remote, ip_addr_local, ICMP_TYPE, 8'h00};

    // Shift the current byte's template and mask slot to the top.
    // This avoids a variable-index select.
    assign tmpl_sh = tmpl << {count[5:0], 3'b000};
    assign mask_sh = CHK_MASK << count[5:0];

    // Compare the current header byte against the template when it is a checked position.
    always_comb begin
        byte_ok = 1'b1;
        if (state == ST_HEADER && count < CHK_BYTES && mask_sh[35] &&
            s_axis_tdata != tmpl_sh[287:280])
            byte_ok = 1'b0;
    end

    // Shift captured header fields. This path also feeds the outputs, so byte 41 lands
    // even when it carries tlast.
    always_comb begin
        frame_nxt = frame_cap;
        log_nxt   = log_cap;
        ping_nxt  = ping_cap;
        if (s_axis_tvalid && state == ST_HEADER) begin
            case (count)
                16'd18, 16'd19: frame_nxt = {frame_cap[7:0], s_axis_tdata};
                16'd38, 16'd39: log_nxt   = {log_cap[7:0], s_axis_tdata};
                16'd40, 16'd41: ping_nxt  = {ping_cap[7:0], s_axis_tdata};
                default: ;
            endcase
        end
    end

    assign match_nxt = match & byte_ok & ~s_axis_tuser;
    assign accept    = s_axis_tvalid & s_axis_tlast & (count >= HDR_LAST) & match_nxt;
    assign rx_begin  = s_axis_tvalid & (state == ST_HEADER) & (count == 16'd0);

    // Frame walker: byte index, match tracking, header/payload state and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_HEADER;
            count       <= '0;
            match       <= 1'b1;
            frame_cap   <= '0;
            log_cap     <= '0;
            ping_cap    <= '0;
            rx_valid    <= 1'b0;
            rx_frame_id <= '0;
            rx_log_id   <= '0;
            rx_ping_id  <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (s_axis_tvalid) begin
                frame_cap <= frame_nxt;
                log_cap   <= log_nxt;
                ping_cap  <= ping_nxt;
                if (s_axis_tlast) begin
                    count <= '0;
                    match <= 1'b1;
                    state <= ST_HEADER;
                    if (accept) begin
                        rx_valid    <= 1'b1;
                        rx_frame_id <= frame_nxt;
                        rx_log_id   <= log_nxt;
                        rx_ping_id  <= ping_nxt;
                    end
                end else begin
                    if (count != 16'hFFFF)
                        count <= count + 16'd1;
                    match <= match_nxt;
                    if (state == ST_HEADER && count == HDR_LAST)
                        state <= ST_PAYLOAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_latency_measurer_rx.sv
// Directed bench for eth_latency_measurer_rx.
// A reply-mode instance and a request-mode instance share one stimulus stream.
module tb_eth_latency_measurer_rx;

    localparam logic [47:0] MAC_L = 48'h02_11_22_33_44_55;
    localparam logic [47:0] MAC_R = 48'h02_66_77_88_99_AA;
    localparam logic [31:0] IP_L  = 32'hC0A8_0102;
    localparam logic [31:0] IP_R  = 32'h0A00_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tdata = '0;
    logic        tuser = 1'b0, tlast = 1'b0, tvalid = 1'b0;
    logic        rx_begin0, rx_valid0, rx_begin1, rx_valid1;
    logic [15:0] fid0, lid0, pid0, fid1, lid1, pid1;

    always #5 clk = ~clk;

    eth_latency_measurer_rx #(.C_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .rx_begin(rx_begin0),
        .mac_addr_local(MAC_L), .mac_addr_remote(MAC_R),
        .ip_addr_local(IP_L), .ip_addr_remote(IP_R),
        .rx_valid(rx_valid0), .rx_frame_id(fid0), .rx_log_id(lid0), .rx_ping_id(pid0),
        .s_axis_tdata(tdata), .s_axis_tuser(tuser), .s_axis_tlast(tlast), .s_axis_tvalid(tvalid)
    );

    eth_latency_measurer_rx #(.C_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .rx_begin(rx_begin1),
        .mac_addr_local(MAC_L), .mac_addr_remote(MAC_R),
        .ip_addr_local(IP_L), .ip_addr_remote(IP_R),
        .rx_valid(rx_valid1), .rx_frame_id(fid1), .rx_log_id(lid1), .rx_ping_id(pid1),
        .s_axis_tdata(tdata), .s_axis_tuser(tuser), .s_axis_tlast(tlast), .s_axis_tvalid(tvalid)
    );

    // Stimulus stream
    logic [7:0] sdata [256];
    logic       slast [256];
    logic       suser [256];
    int         slen;
    int         cur_idx = -1;

    // Monitor state
    int cyc = 0, vcnt0 = 0, vcnt1 = 0, bcnt = 0, bidx = -1, vcyc = 0, tl_cyc = 0;
    int nchk = 0, nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid0) begin vcnt0 = vcnt0 + 1; vcyc = cyc; end
        if (rx_valid1) vcnt1 = vcnt1 + 1;
        if (rx_begin0) begin bcnt = bcnt + 1; bidx = cur_idx; end
        if (tvalid && tlast) tl_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        vcnt0 = 0; vcnt1 = 0; bcnt = 0; bidx = -1;
    endtask

    task automatic build(input int base, input int len, input logic [7:0] typ,
                         input logic [15:0] id, input logic [15:0] lid, input logic [15:0] pid);
        logic [7:0] f [60];
        for (int k = 0; k < 6; k++) begin
            f[k]   = MAC_L[47-8*k -: 8];
            f[6+k] = MAC_R[47-8*k -: 8];
        end
        f[12] = 8'h08; f[13] = 8'h00; f[14] = 8'h45; f[15] = 8'h00;
        f[16] = 8'h00; f[17] = 8'h1C; f[18] = id[15:8]; f[19] = id[7:0];
        f[20] = 8'h40; f[21] = 8'h00; f[22] = 8'h40; f[23] = 8'h01;
        f[24] = 8'hAB; f[25] = 8'hCD;
        for (int k = 0; k < 4; k++) begin
            f[26+k] = IP_R[31-8*k -: 8];
            f[30+k] = IP_L[31-8*k -: 8];
        end
        f[34] = typ; f[35] = 8'h00; f[36] = 8'h55; f[37] = 8'hAA;
        f[38] = lid[15:8]; f[39] = lid[7:0]; f[40] = pid[15:8]; f[41] = pid[7:0];
        for (int k = 42; k < 60; k++) f[k] = 8'(k);
        for (int k = 0; k < len; k++) begin
            sdata[base+k] = f[k];
            slast[base+k] = (k == len - 1);
            suser[base+k] = 1'b0;
        end
        slen = base + len;
    endtask

    // Drive the stream with 5-cycle tvalid gaps before gap_a/gap_b, and an async reset pulse during rst_at.
    task automatic play(input int gap_a, input int gap_b, input int rst_at);
        for (int i = 0; i < slen; i++) begin
            @(posedge clk); #1;
            if (i == gap_a || i == gap_b) begin
                tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
                repeat (5) @(posedge clk);
                #1;
            end
            cur_idx = i;
            tdata = sdata[i]; tlast = slast[i]; tuser = suser[i]; tvalid = 1'b1;
            if (i == rst_at) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; cur_idx = -1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    int         cpos [4] = '{3, 13, 23, 29};
    logic [7:0] cval [4] = '{8'hCC, 8'h01, 8'h06, 8'h02};

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, rx_valid0}, 0);
        chk("rst_fid", {16'd0, fid0}, 0);
        chk("rst_lid", {16'd0, lid0}, 0);
        chk("rst_pid", {16'd0, pid0}, 0);
        rst = 1'b0;

        // Basic reply frame
        clr(); build(0, 60, 8'h00, 16'h1234, 16'hBEEF, 16'h0007); play(-1, -1, -1);
        chk("reply_vcnt", vcnt0, 1);
        chk("reply_lat", vcyc - tl_cyc, 1);
        chk("reply_fid", {16'd0, fid0}, 32'h1234);
        chk("reply_lid", {16'd0, lid0}, 32'hBEEF);
        chk("reply_pid", {16'd0, pid0}, 32'h0007);
        chk("reply_bcnt", bcnt, 1);
        chk("reply_bidx", bidx, 0);
        chk("reply_m1_vcnt", vcnt1, 0);

        // Request frame: rejected by the reply instance, accepted by the request instance
        clr(); build(0, 60, 8'h08, 16'h1234, 16'hBEEF, 16'h0007); play(-1, -1, -1);
        chk("req_m0_vcnt", vcnt0, 0);
        chk("req_m0_fid", {16'd0, fid0}, 32'h1234);
        chk("req_m1_vcnt", vcnt1, 1);
        chk("req_m1_fid", {16'd0, fid1}, 32'h1234);
        chk("req_m1_lid", {16'd0, lid1}, 32'hBEEF);
        chk("req_m1_pid", {16'd0, pid1}, 32'h0007);

        // Single-byte corruptions
        for (int c = 0; c < 4; c++) begin
            clr(); build(0, 60, 8'h00, 16'h5555, 16'h6666, 16'h7777);
            sdata[cpos[c]] = cval[c];
            play(-1, -1, -1);
            chk($sformatf("corrupt%0d_vcnt", cpos[c]), vcnt0, 0);
        end
        chk("corrupt_fid_hold", {16'd0, fid0}, 32'h1234);

        // Truncated frame followed back-to-back by a valid frame
        clr(); build(0, 31, 8'h00, 16'h1111, 16'h1111, 16'h1111);
        build(31, 60, 8'h00, 16'h2222, 16'h3333, 16'h0009); play(-1, -1, -1);
        chk("trunc_vcnt", vcnt0, 1);
        chk("trunc_lat", vcyc - tl_cyc, 1);
        chk("trunc_fid", {16'd0, fid0}, 32'h2222);
        chk("trunc_lid", {16'd0, lid0}, 32'h3333);
        chk("trunc_pid", {16'd0, pid0}, 32'h0009);
        chk("trunc_bcnt", bcnt, 2);
        chk("trunc_bidx", bidx, 31);

        // Minimum-length frame: tlast on byte 41
        clr(); build(0, 42, 8'h00, 16'h4242, 16'h0042, 16'h0041); play(-1, -1, -1);
        chk("min_vcnt", vcnt0, 1);
        chk("min_fid", {16'd0, fid0}, 32'h4242);
        chk("min_pid", {16'd0, pid0}, 32'h0041);

        // MAC error flag on the last beat, then on byte 10
        clr(); build(0, 60, 8'h00, 16'h9999, 16'h9999, 16'h9999); suser[59] = 1'b1; play(-1, -1, -1);
        chk("tuser_last_vcnt", vcnt0, 0);
        clr(); build(0, 60, 8'h00, 16'h9999, 16'h9999, 16'h9999); suser[10] = 1'b1; play(-1, -1, -1);
        chk("tuser_b10_vcnt", vcnt0, 0);
        chk("tuser_fid_hold", {16'd0, fid0}, 32'h4242);

        // tvalid gaps before bytes 20 and 40
        clr(); build(0, 60, 8'h00, 16'hA5A5, 16'h5A5A, 16'h0100); play(20, 40, -1);
        chk("gap_vcnt", vcnt0, 1);
        chk("gap_lat", vcyc - tl_cyc, 1);
        chk("gap_fid", {16'd0, fid0}, 32'hA5A5);
        chk("gap_lid", {16'd0, lid0}, 32'h5A5A);
        chk("gap_pid", {16'd0, pid0}, 32'h0100);

        // Asynchronous reset at byte 25, then a clean frame
        clr(); build(0, 60, 8'h00, 16'h7E7E, 16'h7E7E, 16'h7E7E); play(-1, -1, 25);
        chk("rstmid_vcnt", vcnt0, 0);
        chk("rstmid_fid", {16'd0, fid0}, 0);
        chk("rstmid_lid", {16'd0, lid0}, 0);
        chk("rstmid_pid", {16'd0, pid0}, 0);
        clr(); build(0, 60, 8'h00, 16'h0BAD, 16'hCAFE, 16'h00FF); play(-1, -1, -1);
        chk("post_rst_vcnt", vcnt0, 1);
        chk("post_rst_fid", {16'd0, fid0}, 32'h0BAD);
        chk("post_rst_lid", {16'd0, lid0}, 32'hCAFE);
        chk("post_rst_pid", {16'd0, pid0}, 32'h00FF);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    // Watchdog bound
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/eth_latency_measurer_rx.md
Name: eth_latency_measurer_rx

Overview:
Receive-side parser for latency-measurement ICMP echo traffic on a byte-wide AXI-Stream from the Ethernet MAC. It checks each frame's Ethernet/IPv4/ICMP headers against configured addresses and the expected ICMP type. For each accepted frame it outputs the IP identification, ICMP identifier and sequence fields, plus a start-of-frame strobe used for timestamping. An initiator-side instance (C_MODE=0) detects echo replies; a responder-side instance (C_MODE=1) detects echo requests.

Parameters:
C_MODE, 0, expected ICMP type: 0 → accept only type 0x00 (reply); 1 → accept only type 0x08 (request)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rx_begin  out  1  one-cycle strobe on byte 0 of every frame (combinational from s_axis_tvalid and state)
mac_addr_local  in  48  required destination MAC
mac_addr_remote  in  48  required source MAC
ip_addr_local  in  32  required IPv4 destination
ip_addr_remote  in  32  required IPv4 source
rx_valid  out  1  one-cycle pulse, frame accepted
rx_frame_id  out  16  IPv4 identification (bytes 18-19) of last accepted frame
rx_log_id  out  16  ICMP identifier (bytes 38-39) of last accepted frame
rx_ping_id  out  16  ICMP sequence (bytes 40-41) of last accepted frame
s_axis_tdata  in  8  frame byte, MSB-first field order
s_axis_tuser  in  1  MAC error flag, valid on any beat
s_axis_tlast  in  1  last byte of frame
s_axis_tvalid  in  1  beat valid; no tready, receiver always accepts

Behaviour:
- Reset: state=ST_HEADER, count=0, match=1. rx_valid=0, rx_frame_id=rx_log_id=rx_ping_id=0.
- count: 16-bit byte index within the frame. Increments on each valid beat and saturates at 0xFFFF. It clears to 0 on a tlast beat.
- States:
  - ST_HEADER: bytes 0..41. Each byte is compared against its expected value; any mismatch clears match. Bytes 18-19 and 38-41 are shifted into capture registers.
    - tlast with count<41 → discard frame, stay in ST_HEADER.
    - count==41 without tlast → ST_PAYLOAD.
    - count==41 with tlast → end of frame (see acceptance).
  - ST_PAYLOAD: padding bytes, contents ignored. tlast → end of frame, then ST_HEADER.
- Checked bytes:
  - 0-5 = mac_addr_local
  - 6-11 = mac_addr_remote
  - 12-13 = 0x0800
  - 14 = 0x45
  - 16-17 = 0x001C
  - 23 = 0x01
  - 26-29 = ip_addr_remote
  - 30-33 = ip_addr_local
  - 34 = (C_MODE ? 0x08 : 0x00)
  - 35 = 0x00
- Not checked: bytes 15, 20-22, 24-25, 36-37. IP and ICMP checksums are not verified.
- tuser=1 on any beat clears match for the current frame.
- Acceptance: on the tlast beat, when count≥41, match=1 and tuser=0 on that beat:
  - rx_valid=1 in the next cycle, for exactly one cycle.
  - rx_frame_id, rx_log_id and rx_ping_id load from the capture registers in that same cycle.
  - Outputs hold until the next accepted frame. Rejected frames never alter them.
- After each tlast: count=0, match=1, state=ST_HEADER. Back-to-back frames (tlast followed immediately by byte 0) are supported with no idle cycle.
- rx_begin = s_axis_tvalid & state==ST_HEADER & count==0. It is asserted for every frame, including ones later rejected.
- s_axis_tvalid low: hold all state; gaps mid-frame are allowed.
- Reset mid-frame: everything returns to reset values immediately. The frame remainder is parsed from byte 0 and normally fails the MAC checks; at most one spurious rx_begin is allowed, and no rx_valid.

Test Plan:
- C_MODE=0. Reply frame: local/remote MACs and IPs matching, type 0x00, id 0x1234, log_id 0xBEEF, ping_id 0x0007, 18 padding bytes, tlast on last → one rx_valid pulse the cycle after tlast; outputs 0x1234/0xBEEF/0x0007; rx_begin high on byte 0 only.
- Same frame with byte 34=0x08 (request) at C_MODE=0 → no rx_valid, outputs unchanged. Same frame at C_MODE=1 → accepted.
- Corruption, one per frame: byte 3 (dst MAC), byte 13 (0x0801), byte 23 (0x06), byte 29 (IP src) → no rx_valid in each case.
- Truncation at byte 30 (tlast), then a valid frame back-to-back → first dropped; second yields rx_valid and rx_begin on its byte 0.
- Valid frame with tuser=1 on the tlast beat; repeated with tuser=1 on byte 10 → no rx_valid either time.
- tvalid deasserted for 5 cycles at bytes 20 and 40 → still accepted, with correct ids. Async rst asserted at byte 25 → rx_valid=0, outputs reset to 0; a following valid frame is accepted.
